mcs4_ram_bank: RTL and testbench
================================

MCS4_RAM_BANK -- requirements
Module: mcs4_ram_bank

Interface
REQ-001 SHALL have parameter NUM_CHIPS, default 4, number of 4002-style chips in the bank (1..4).
REQ-002 SHALL have parameter REGS_PER_CHIP, default 4, registers per chip (power of 2, max 4).
REQ-003 SHALL have parameter CHARS_PER_REG, default 16, main characters per register (power of 2, max 16).
REQ-004 SHALL have parameter STATUS_PER_REG, default 4, status characters per register (1..4).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sync  input  1  instruction-cycle marker; the cycle carrying it is A1.
REQ-008 SHALL have port cm_ram  input  1  this bank's CM-RAM line.
REQ-009 SHALL have port dbus_in  input  4  data bus from CPU.
REQ-010 SHALL have port dbus_out  output  4  read data; 0 when dbus_oe low.
REQ-011 SHALL have port dbus_oe  output  1  bank is driving the data bus.
REQ-012 SHALL have port io_out  output  4*NUM_CHIPS  output-port latches, chip n at bits [4n+3:4n].

Function
REQ-013 SHALL keep a 3-bit phase counter: 0 (A1) on a sync cycle, otherwise +1, saturating at 7 (X3) until the next sync; phases A1,A2,A3,M1,M2,X1,X2,X3 = 0..7.
REQ-014 SHALL capture SRC when cm_ram=1 in X2: dbus_in[3:2]=chip, [1:0]=register; and set src_pend.
REQ-015 SHALL capture the character index from dbus_in in X3 only if src_pend, then clear src_pend; address holds until the next SRC.
REQ-016 SHALL latch opa=dbus_in and set op_valid when cm_ram=1 in M2; op_valid SHALL clear in X3.
REQ-017 SHALL treat the bank as selected when latched chip < NUM_CHIPS; register/character bits above the parameterised width SHALL be ignored (address wraps modulo depth).
REQ-018 SHALL, in X2 with op_valid and selected, commit on that clock edge: WRM(0) main char = dbus_in; WMP(1) io_out[chip] = dbus_in; WR0-WR3(4-7) status[n] = dbus_in.
REQ-019 SHALL treat WRR(2), WPM(3), RDR(A) and status index >= STATUS_PER_REG as no-ops: no write, dbus_oe=0.
REQ-020 SHALL, in X2 with op_valid and selected, for SBM(8), RDM(9), ADM(B) drive dbus_out = addressed main char, and for RD0-RD3(C-F) the addressed status char, with dbus_oe=1, combinationally (zero latency).
REQ-021 SHALL hold dbus_oe=0 and dbus_out=0 in every other phase/condition.
REQ-022 SHALL, when a write and new SRC would coincide (impossible in one instruction cycle), give no priority; an SRC arriving with op_valid set SHALL update the address after the X2 access completes.
REQ-023 SHALL leave memory and io_out unchanged by a sync arriving mid-cycle; an aborted cycle (sync before X2) SHALL perform no access, op_valid cleared on sync.

Reset
REQ-024 SHALL on rst_n=0 immediately set phase=7, op_valid=0, src_pend=0, address=0, io_out=0, dbus_oe=0, dbus_out=0.
REQ-025 SHALL NOT reset main or status memory contents.
REQ-026 SHALL perform no access in the instruction cycle during which rst_n deasserts; operation resumes at the next sync.

Configuration
REQ-027 SHALL honour macro MCS4_RAM_STATUS_EN: defined -> status storage and WR0-3/RD0-3 as above.
REQ-028 SHALL, without MCS4_RAM_STATUS_EN, instantiate no status storage; WR0-3 no-ops, RD0-3 drive dbus_out=0 with dbus_oe=1.

Verification
REQ-029 SHALL cover: SRC 0x1,0x5 then WRM 0xA, then RDM -> dbus_out=0xA, dbus_oe=1 in X2 only.
REQ-030 SHALL cover: NUM_CHIPS=2, SRC chip 3 then WRM 0x7 -> no write, RDM dbus_oe=0; chip 1 data unchanged.
REQ-031 SHALL cover: WMP 0x9 to chip 2 -> io_out[11:8]=0x9, other nibbles 0; held across subsequent instructions.
REQ-032 SHALL cover: WR3 0xC then RD3 -> 0xC with macro; RD3 -> 0x0, dbus_oe=1 without macro.
REQ-033 SHALL cover: rst_n low during M2 of WRM -> no write, io_out=0, dbus_oe=0; reads after next sync return prior memory value.
REQ-034 SHALL cover: cm_ram=0 in M2 of RDM -> dbus_oe=0 in X2; WRR/RDR opcodes -> no state change.

Source files
------------

// File: rtl/mcs4_ram_bank_if.sv
// CPU-side bus of an MCS-4 RAM bank.
//   sync     : instruction-cycle marker, the cycle carrying it is A1
//   cm_ram   : this bank's CM-RAM select line
//   dbus_in  : 4-bit data bus driven by the CPU
//   dbus_out : read data from the bank, 0 whenever dbus_oe is low
//   dbus_oe  : bank is driving the data bus
// master = CPU side, slave = RAM bank side.
interface mcs4_ram_bank_if;
  logic       sync;
  logic       cm_ram;
  logic [3:0] dbus_in;
  logic [3:0] dbus_out;
  logic       dbus_oe;

  modport master (output sync, output cm_ram, output dbus_in,
                  input  dbus_out, input dbus_oe);
  modport slave  (input  sync, input  cm_ram, input  dbus_in,
                  output dbus_out, output dbus_oe);
endinterface

// File: rtl/mcs4_ram_bank.sv
// Bank of 4002-style RAM chips (main characters, optional status characters
// and one 4-bit output port per chip) following the MCS-4 8-phase cycle.
//
// Ports:
//   clk    : single clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mcs4_ram_bank_if.slave (sync, cm_ram, dbus_in, dbus_out, dbus_oe)
//   io_out : output-port latches, chip n at bits [4n+3:4n]
//
// Optional feature: define MCS4_RAM_STATUS_EN to build status-character
// storage (WR0-3 / RD0-3). Without it RD0-3 drive 0 and WR0-3 do nothing.
module mcs4_ram_bank #(
  parameter int NUM_CHIPS      = 4,
  parameter int REGS_PER_CHIP  = 4,
  parameter int CHARS_PER_REG  = 16,
  parameter int STATUS_PER_REG = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mcs4_ram_bank_if.slave         bus,
  output logic [4*NUM_CHIPS-1:0] io_out
);

  typedef enum logic [2:0] {
    PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_t;

  localparam int MAIN_DEPTH = NUM_CHIPS * REGS_PER_CHIP * CHARS_PER_REG;
  localparam int MAIN_AW    = (MAIN_DEPTH > 1) ? $clog2(MAIN_DEPTH) : 1;

  phase_t     phase_q;
  phase_t     phase;
  logic [1:0] chip_q;
  logic [1:0] reg_q;
  logic [3:0] char_q;
  logic       src_pend;
  logic       op_valid;
  logic [3:0] opa;

  logic               sel;
  logic               access;
  logic               wr_main;
  logic               wr_io;
  logic               st_ok;
  logic [MAIN_AW-1:0] main_idx;
  logic [3:0]         dout;
  logic               oe;

  logic [3:0] main_mem [MAIN_DEPTH];

  // phase_q holds the previous cycle's phase; the current phase is derived
  // combinationally so the sync cycle itself is A1.
  always_comb begin
    if (bus.sync)               phase = PH_A1;
    else if (phase_q == PH_X3)  phase = PH_X3;
    else                        phase = phase_t'(phase_q + 3'd1);
  end

  assign sel    = 32'(chip_q) < NUM_CHIPS;
  assign access = (phase == PH_X2) && op_valid && sel;
  assign st_ok  = 32'(opa[1:0]) < STATUS_PER_REG;

  // Register/character bits beyond the configured depth wrap.
  assign main_idx = MAIN_AW'(32'(chip_q) * REGS_PER_CHIP * CHARS_PER_REG
                           + (32'(reg_q) % REGS_PER_CHIP) * CHARS_PER_REG
                           + (32'(char_q) % CHARS_PER_REG));

  assign wr_main = access && (opa == 4'h0);
  assign wr_io   = access && (opa == 4'h1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_X3;
      op_valid <= 1'b0;
      src_pend <= 1'b0;
      chip_q   <= '0;
      reg_q    <= '0;
      char_q   <= '0;
      opa      <= '0;
      io_out   <= '0;
    end else begin
      phase_q <= phase;

      if (bus.sync || phase == PH_X3) begin
        op_valid <= 1'b0;
      end else if (phase == PH_M2 && bus.cm_ram) begin
        opa      <= bus.dbus_in;
        op_valid <= 1'b1;
      end

      // An SRC seen in X2 while an access is in flight takes effect after
      // this edge, so the access above still uses the old address.
      if (phase == PH_X2 && bus.cm_ram) begin
        chip_q   <= bus.dbus_in[3:2];
        reg_q    <= bus.dbus_in[1:0];
        src_pend <= 1'b1;
      end else if (phase == PH_X3 && src_pend) begin
        char_q   <= bus.dbus_in;
        src_pend <= 1'b0;
      end

      for (int unsigned n = 0; n < NUM_CHIPS; n++) begin
        if (wr_io && 32'(chip_q) == n) io_out[4*n +: 4] <= bus.dbus_in;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_main) main_mem[main_idx] <= bus.dbus_in;
  end

`ifdef MCS4_RAM_STATUS_EN
  localparam int STAT_DEPTH = NUM_CHIPS * REGS_PER_CHIP * STATUS_PER_REG;
  localparam int STAT_AW    = (STAT_DEPTH > 1) ? $clog2(STAT_DEPTH) : 1;

  logic [3:0]         stat_mem [STAT_DEPTH];
  logic [STAT_AW-1:0] stat_idx;
  logic               wr_stat;

  assign stat_idx = STAT_AW'(32'(chip_q) * REGS_PER_CHIP * STATUS_PER_REG
                           + (32'(reg_q) % REGS_PER_CHIP) * STATUS_PER_REG
                           + 32'(opa[1:0]));
  assign wr_stat  = access && (opa[3:2] == 2'b01) && st_ok;

  always_ff @(posedge clk) begin
    if (wr_stat) stat_mem[stat_idx] <= bus.dbus_in;
  end
`endif

  always_comb begin
    dout = '0;
    oe   = 1'b0;
    if (access) begin
      case (opa)
        4'h8, 4'h9, 4'hB: begin
          oe   = 1'b1;
          dout = main_mem[main_idx];
        end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          oe = st_ok;
`ifdef MCS4_RAM_STATUS_EN
          if (st_ok) dout = stat_mem[stat_idx];
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.dbus_out = dout;
  assign bus.dbus_oe  = oe;

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// Directed self-checking bench for mcs4_ram_bank. Two banks share the same
// stimulus: dut_a with 4 chips, dut_b with 2 chips (chips 2/3 unselected).
module tb_mcs4_ram_bank;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       sync   = 1'b0;
  logic       cm_ram = 1'b0;
  logic [3:0] dbus   = 4'h0;
  logic [15:0] io_a;
  logic [7:0]  io_b;

  int checks   = 0;
  int failures = 0;

  logic [7:0] oe_a, oe_b;
  logic [3:0] out_a [8];
  logic [3:0] out_b [8];

  mcs4_ram_bank_if bus_a ();
  mcs4_ram_bank_if bus_b ();

  assign bus_a.sync    = sync;
  assign bus_a.cm_ram  = cm_ram;
  assign bus_a.dbus_in = dbus;
  assign bus_b.sync    = sync;
  assign bus_b.cm_ram  = cm_ram;
  assign bus_b.dbus_in = dbus;

  mcs4_ram_bank #(.NUM_CHIPS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .io_out(io_a)
  );
  mcs4_ram_bank #(.NUM_CHIPS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .io_out(io_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One 8-phase instruction cycle; outputs sampled 2ns after each negedge.
  // rst_p: phase in which rst_n is pulsed low for one clock (-1 = none).
  task automatic instr(input logic [3:0] m2_d, input logic cm_m2,
                       input logic [3:0] x2_d, input logic cm_x2,
                       input logic [3:0] x3_d, input int rst_p);
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      if (p == rst_p) rst_n = 1'b0;
      else if (p == rst_p + 1) rst_n = 1'b1;
      sync   = (p == 0);
      cm_ram = (p == 4) ? cm_m2 : (p == 6) ? cm_x2 : 1'b0;
      dbus   = (p == 4) ? m2_d : (p == 6) ? x2_d : (p == 7) ? x3_d : 4'h0;
      #2;
      oe_a[p]  = bus_a.dbus_oe;
      out_a[p] = bus_a.dbus_out;
      oe_b[p]  = bus_b.dbus_oe;
      out_b[p] = bus_b.dbus_out;
    end
  endtask

  task automatic src(input logic [1:0] chip, input logic [1:0] rg, input logic [3:0] ch);
    instr(4'h0, 1'b0, {chip, rg}, 1'b1, ch, -1);
  endtask

  task automatic io(input logic [3:0] op, input logic [3:0] d);
    instr(op, 1'b1, d, 1'b0, 4'h0, -1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("rst_io_a", 32'(io_a), 32'h0);
    check("rst_io_b", 32'(io_b), 32'h0);
    check("rst_oe_a", 32'(bus_a.dbus_oe), 32'h0);
    check("rst_out_a", 32'(bus_a.dbus_out), 32'h0);
    rst_n = 1'b1;

    // WRM then RDM at chip0 reg1 char5
    src(2'd0, 2'd1, 4'h5);
    io(4'h0, 4'hA);
    io(4'h9, 4'h0);
    check("rdm_oe_a", 32'(oe_a), 32'h40);
    check("rdm_out_a", 32'(out_a[6]), 32'hA);
    check("rdm_out_x1_a", 32'(out_a[5]), 32'h0);
    check("rdm_oe_b", 32'(oe_b), 32'h40);
    check("rdm_out_b", 32'(out_b[6]), 32'hA);

    // Unselected chip in the 2-chip bank
    src(2'd1, 2'd0, 4'h2);
    io(4'h0, 4'h3);
    src(2'd3, 2'd0, 4'h2);
    io(4'h0, 4'h7);
    io(4'h9, 4'h0);
    check("chip3_oe_a", 32'(oe_a), 32'h40);
    check("chip3_out_a", 32'(out_a[6]), 32'h7);
    check("chip3_oe_b", 32'(oe_b), 32'h0);
    check("chip3_out_b", 32'(out_b[6]), 32'h0);
    src(2'd1, 2'd0, 4'h2);
    io(4'h9, 4'h0);
    check("chip1_out_a", 32'(out_a[6]), 32'h3);
    check("chip1_out_b", 32'(out_b[6]), 32'h3);
    check("chip1_oe_b", 32'(oe_b), 32'h40);

    // WMP to chip 2
    src(2'd2, 2'd0, 4'h0);
    io(4'h1, 4'h9);
    check("wmp_io_a", 32'(io_a), 32'h0900);
    check("wmp_io_b", 32'(io_b), 32'h00);
    check("wmp_oe_a", 32'(oe_a), 32'h0);
    io(4'h2, 4'h4);
    src(2'd0, 2'd1, 4'h5);
    check("wmp_hold_a", 32'(io_a), 32'h0900);

    // WR3 then RD3 at chip2 reg1
    src(2'd2, 2'd1, 4'h0);
    io(4'h7, 4'hC);
    io(4'hF, 4'h0);
    check("rd3_oe_a", 32'(oe_a), 32'h40);
`ifdef MCS4_RAM_STATUS_EN
    check("rd3_out_a", 32'(out_a[6]), 32'hC);
`else
    check("rd3_out_a", 32'(out_a[6]), 32'h0);
`endif
    check("rd3_oe_b", 32'(oe_b), 32'h0);

    // Reset pulse in M2 of a WRM
    src(2'd0, 2'd1, 4'h5);
    instr(4'h0, 1'b1, 4'h6, 1'b0, 4'h0, 4);
    check("rstm2_oe_a", 32'(oe_a), 32'h0);
    check("rstm2_io_a", 32'(io_a), 32'h0);
    check("rstm2_io_b", 32'(io_b), 32'h0);
    src(2'd0, 2'd1, 4'h5);
    io(4'h9, 4'h0);
    check("rstm2_rd_a", 32'(out_a[6]), 32'hA);
    check("rstm2_rd_b", 32'(out_b[6]), 32'hA);

    // cm_ram low in M2, WRR/WPM/RDR no-ops
    io(4'h1, 4'h5);
    check("wmp0_io_a", 32'(io_a), 32'h0005);
    check("wmp0_io_b", 32'(io_b), 32'h05);
    instr(4'h9, 1'b0, 4'h0, 1'b0, 4'h0, -1);
    check("nocm_oe_a", 32'(oe_a), 32'h0);
    io(4'h2, 4'hF);
    check("wrr_oe_a", 32'(oe_a), 32'h0);
    check("wrr_io_a", 32'(io_a), 32'h0005);
    io(4'h3, 4'hF);
    io(4'hA, 4'h0);
    check("rdr_oe_a", 32'(oe_a), 32'h0);
    check("rdr_out_a", 32'(out_a[6]), 32'h0);
    io(4'h9, 4'h0);
    check("noop_mem_a", 32'(out_a[6]), 32'hA);
    check("noop_io_a", 32'(io_a), 32'h0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
